// File: rtl/aes_inv_key_gen_if.sv
// Handshake and shared S-box bundle for the inverse AES-128 key generator.
// The slave modport is the generator side; the master side is its user.
interface aes_inv_key_gen_if;
    logic         en;
    logic         start;
    logic [127:0] key_i;
    logic         busy;
    logic [127:0] key_o;
    logic         key_vld;
    logic         key_rdy;
    logic [3:0]   rnd_o;
    logic         done;
    logic [31:0]  sub_o;
    logic [31:0]  sub_i;

    modport master (
        output en, start, key_i, key_rdy, sub_i,
        input  busy, key_o, key_vld, rnd_o, done, sub_o
    );

    modport slave (
        input  en, start, key_i, key_rdy, sub_i,
        output busy, key_o, key_vld, rnd_o, done, sub_o
    );
endinterface

// File: rtl/aes_inv_key_gen.sv
// Reverse AES-128 key schedule: streams K9..K0 from K10 via a shared S-box.
// AES_INV_KEY_GEN_FWD_EN: key_i is K0 and a forward pass derives K10 first.
module aes_inv_key_gen #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_LAST = 8'h36
) (
    input logic              clk,
    input logic              rst,
    aes_inv_key_gen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FWD, S_STEP, S_STREAM} state_t;

    state_t       r_state;
    logic [127:0] r_work;
    logic [127:0] r_key;
    logic [7:0]   r_rcon;
    logic [3:0]   r_rnd;
    logic         r_vld;
    logic         r_done;
`ifdef AES_INV_KEY_GEN_FWD_EN
    logic [3:0]   r_fcnt;
`endif

    logic [127:0] w_src;
    logic [31:0]  w_v3;
    logic [31:0]  w_sub;
    logic [31:0]  w_v0;
    logic [127:0] w_prev;

    function automatic logic [31:0] rotw(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Inverse of xtime: undoes the 0x1b reduction when the low bit is set.
    function automatic logic [7:0] rcon_dn(input logic [7:0] rc);
        return rc[0] ? (((rc ^ 8'h1b) >> 1) | 8'h80) : (rc >> 1);
    endfunction

    always_comb begin
        w_src = (r_state == S_STEP) ? r_work : r_key;
        w_v3  = w_src[31:0] ^ w_src[63:32];
        case (r_state)
            S_IDLE:  w_sub = '0;
            S_FWD:   w_sub = rotw(r_work[31:0]);
            default: w_sub = rotw(w_v3);
        endcase
        w_v0   = w_src[127:96] ^ bus.sub_i ^ {r_rcon, 24'h0};
        w_prev = {w_v0,
                  w_src[95:64] ^ w_src[127:96],
                  w_src[63:32] ^ w_src[95:64],
                  w_v3};
    end

`ifdef AES_INV_KEY_GEN_FWD_EN
    logic [31:0] w_f0, w_f1, w_f2, w_f3;

    always_comb begin
        w_f0 = r_work[127:96] ^ bus.sub_i ^ {r_rcon, 24'h0};
        w_f1 = r_work[95:64] ^ w_f0;
        w_f2 = r_work[63:32] ^ w_f1;
        w_f3 = r_work[31:0] ^ w_f2;
    end
`endif

    assign bus.sub_o   = w_sub;
    assign bus.key_o   = r_key;
    assign bus.key_vld = r_vld;
    assign bus.rnd_o   = r_rnd;
    assign bus.done    = r_done;
    assign bus.busy    = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_key   <= '0;
            r_rcon  <= RCON_LAST;
            r_rnd   <= '0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
`ifdef AES_INV_KEY_GEN_FWD_EN
            r_fcnt  <= '0;
`endif
        end else if (bus.en) begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_work <= bus.key_i;
`ifdef AES_INV_KEY_GEN_FWD_EN
                        r_rcon  <= 8'h01;
                        r_fcnt  <= '0;
                        r_state <= S_FWD;
`else
                        r_rcon  <= RCON_LAST;
                        r_state <= S_STEP;
`endif
                    end
                end
                S_FWD: begin
`ifdef AES_INV_KEY_GEN_FWD_EN
                    r_work <= {w_f0, w_f1, w_f2, w_f3};
                    r_fcnt <= r_fcnt + 4'd1;
                    if (r_fcnt == 4'(NR - 1)) begin
                        r_rcon  <= RCON_LAST;
                        r_state <= S_STEP;
                    end else begin
                        r_rcon <= {r_rcon[6:0], 1'b0} ^
                                  (r_rcon[7] ? 8'h1b : 8'h00);
                    end
`else
                    r_state <= S_IDLE;
`endif
                end
                S_STEP: begin
                    r_key   <= w_prev;
                    r_rnd   <= 4'(NR - 1);
                    r_vld   <= 1'b1;
                    r_rcon  <= rcon_dn(r_rcon);
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    if (bus.key_rdy) begin
                        if (r_rnd == 4'd0) begin
                            r_vld   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_key  <= w_prev;
                            r_rnd  <= r_rnd - 4'd1;
                            r_rcon <= rcon_dn(r_rcon);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/aes_inv_key_gen.md
Name: aes_inv_key_gen

Overview:
- Reverse-direction AES-128 key schedule for the decryption datapath.
- Takes the final round key (K10) and streams the round keys K9, K8, … K0 one per handshake, in the order the inverse cipher consumes them.
- Uses an external shared S-box through a combinational word request/return pair, the same arrangement the forward key generator uses.
- An iterative state machine steps rounds and generates the reverse Rcon sequence internally.

Parameters:
- NR, 10, number of rounds. Only 10 is supported; the round counter is 4 bits.
- RCON_LAST, 8'h36, Rcon byte used for the K10->K9 step. Must be consistent with NR.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- en  input  1  clock enable. When 0, all state, outputs and handshakes are frozen.
- start  input  1  single-cycle request; sampled only in IDLE with en=1
- key_i  input  128  K10 (last round key). Bits [127:96] are word w0, in FIPS-197 byte order.
- busy  output  1  high in any state other than IDLE
- key_o  output  128  current round key
- key_vld  output  1  key_o and rnd_o are valid
- key_rdy  input  1  consumer accepts key_o when key_vld && key_rdy && en
- rnd_o  output  4  round index of key_o (9..0)
- done  output  1  one-cycle pulse after K0 is accepted
- sub_o  output  32  word sent to the shared S-box
- sub_i  input  32  SubWord(sub_o), returned combinationally in the same cycle

Behaviour:
- Reset (rst=1 at a clk edge, regardless of en):
  - state=IDLE
  - key_o=0, key_vld=0, rnd_o=0, done=0, busy=0
  - work register=0, rcon register=RCON_LAST
  - Reset mid-stream aborts the stream; no done pulse is generated.
- Inverse step prev(K), with K = w0..w3:
  - v3 = w3^w2
  - v2 = w2^w1
  - v1 = w1^w0
  - v0 = w0 ^ sub_i ^ {rcon,24'h0}
  - sub_o = RotWord(v3) = {v3[23:0],v3[31:24]}
- Reverse Rcon update, applied after each step: rcon_next = rcon[0] ? ((rcon^8'h1b)>>1)|8'h80 : rcon>>1.
  - Resulting sequence: 36,1b,80,40,20,10,08,04,02,01.
- FSM states:
  - IDLE: on start && en: work <= key_i, rcon <= RCON_LAST, go to STEP. start is ignored in all other states.
  - STEP: key_o <= prev(work), rnd_o <= 9, key_vld <= 1, update rcon, go to STREAM.
  - STREAM, on a handshake with rnd_o != 0: key_o <= prev(key_o), rnd_o <= rnd_o-1, update rcon, key_vld stays 1.
  - STREAM, on a handshake with rnd_o == 0: key_vld <= 0, done <= 1 for one cycle, go to IDLE.
  - STREAM, with no handshake: key_o, rnd_o and rcon are held stable.
- Latency and throughput:
  - start to first key_vld: 2 cycles.
  - One key per cycle under continuous key_rdy; the full stream is 11 cycles from start.
- Shared S-box access:
  - sub_o is driven from work in STEP and from key_o in STREAM.
  - In IDLE, sub_o=0.
- en=0 cycles inserted anywhere have no effect other than delay.

Optional Feature:
- Macro: AES_INV_KEY_GEN_FWD_EN.
- Defined:
  - key_i is the cipher key K0.
  - A FWD state runs 10 forward steps before STEP, using the same shared S-box:
    - sub_o = RotWord(w3)
    - w0' = w0 ^ sub_i ^ {rcon_f,24'h0}
    - w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
    - rcon_f = 01..36, using xtime
  - After the 10 forward steps, work holds K10 and the FSM enters STEP.
  - start to first key_vld: 12 cycles. busy is high throughout.
- Undefined: key_i must be K10, there is no FWD state, and latency is 2 cycles.

Test Plan:
- FIPS-197 A.1 stream, key_i=d014f9a8c9ee2589e13f0cc8b6630ca6, key_rdy=1:
  - first key_vld 2 cycles after start, with rnd_o=9 and key_o=ac7766f319fadc2128d12941575c006e.
  - rnd_o=1 gives a0fafe1788542cb123a339392a6c7605.
  - rnd_o=0 gives 2b7e151628aed2a6abf7158809cf4f3c, then a done pulse.
- Backpressure: hold key_rdy=0 for 5 cycles at rnd_o=6:
  - key_o, rnd_o and key_vld are unchanged for those cycles.
  - The stream resumes correctly; K0 still matches.
- Enable gating: en toggled 1/0 every cycle during the stream -> identical key sequence, at half rate.
- Reset mid-stream: rst=1 at rnd_o=4 -> next cycle key_vld=0, busy=0, no done. A new start then gives the correct sequence from K9.
- start asserted while busy -> ignored; the sequence and done timing are unaffected.
- AES_INV_KEY_GEN_FWD_EN, key_i=2b7e151628aed2a6abf7158809cf4f3c -> first key_vld after 12 cycles with key_o=ac7766f3…575c006e; the last key equals key_i.
